// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared record layout, FSM states and widths for the retire trace serializer
package commit_trace_pkg;
  localparam int ORDER_W = 10;
  localparam int PC_W    = 64;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [PC_W-1:0]    prevPc;
    logic [PC_W-1:0]    currPc;
    logic [ORDER_W-1:0] order;
    logic [31:0]        insn;
    logic               fused;
    logic               gprWr;
    logic [7:0]         dest_idx;
    logic               mem_valid;
    logic               isStore;
    logic [PC_W-1:0]    mem_addr;
    logic               halt;
  } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: register FIFO taking up to ENQ_W compacted writes per cycle and one pop
module trace_fifo
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_W = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1,
  localparam int NW = $clog2(ENQ_W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] push_n,
  input  trace_rec_t    push_data [ENQ_W],
  input  logic          pop,
  output trace_rec_t    head,
  output logic [CW-1:0] count
);
  trace_rec_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < ENQ_W; i++)
        if (i < int'(push_n)) mem[wr + AW'(i)] <= push_data[i];
      wr    <= wr + AW'(push_n);
      rd    <= rd + AW'(pop);
      count <= count + CW'(push_n) - CW'(pop);
    end
  assign head = mem[rd];
endmodule

// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer: buffers the multi-lane retire trace and streams it one record at a time
module commit_trace_serializer
  import commit_trace_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int XLEN  = 64,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRET-1:0]         verif_commit_valid,
  input  logic [NRET*XLEN-1:0]    verif_commit_prevPc,
  input  logic [NRET*XLEN-1:0]    verif_commit_currPc,
  input  logic [NRET*ORDER_W-1:0] verif_commit_order,
  input  logic [NRET*32-1:0]      verif_commit_insn,
  input  logic [NRET-1:0]         verif_commit_fused,
  input  logic [NRET-1:0]         verif_sim_halt,
  input  logic [NRET-1:0]         verif_dest_gprWr,
  input  logic [NRET*8-1:0]       verif_dest_idx,
  input  logic [NRET-1:0]         verif_mem_valid,
  input  logic [NRET-1:0]         verif_mem_isStore,
  input  logic [NRET*XLEN-1:0]    verif_mem_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_prevPc,
  output logic [XLEN-1:0]         out_currPc,
  output logic [ORDER_W-1:0]      out_order,
  output logic [31:0]             out_insn,
  output logic [4:0]              out_flags,
  output logic [7:0]              out_dest_idx,
  output logic [XLEN-1:0]         out_mem_addr,
  output logic                    overflow,
  output logic [15:0]             drop_cnt,
  output logic                    order_err,
  output logic                    halt_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NW = $clog2(NRET + 1);
  state_t state, state_n;
  trace_rec_t lane_rec [NRET];
  trace_rec_t push_data [NRET];
  trace_rec_t head;
  logic [CW-1:0] count;
  logic [ORDER_W-1:0] exp_order, exp_n, drop_exp;
  logic pop, accept, drop, halt_hit, err_hit, seen;
  int n_valid, n_push, free;
  always_comb
    for (int i = 0; i < NRET; i++) begin
      lane_rec[i].prevPc    = PC_W'(verif_commit_prevPc[i*XLEN +: XLEN]);
      lane_rec[i].currPc    = PC_W'(verif_commit_currPc[i*XLEN +: XLEN]);
      lane_rec[i].order     = verif_commit_order[i*ORDER_W +: ORDER_W];
      lane_rec[i].insn      = verif_commit_insn[i*32 +: 32];
      lane_rec[i].fused     = verif_commit_fused[i];
      lane_rec[i].gprWr     = verif_dest_gprWr[i];
      lane_rec[i].dest_idx  = verif_dest_idx[i*8 +: 8];
      lane_rec[i].mem_valid = verif_mem_valid[i];
      lane_rec[i].isStore   = verif_mem_isStore[i];
      lane_rec[i].mem_addr  = PC_W'(verif_mem_addr[i*XLEN +: XLEN]);
      lane_rec[i].halt      = verif_sim_halt[i];
    end
  assign out_valid = (count != '0) && (state != DONE);
  assign pop       = out_valid & out_ready;
  // Compact valid lanes, stop after the halting lane, and chain the order check across lanes
  always_comb begin
    n_valid  = 0;
    n_push   = 0;
    halt_hit = 1'b0;
    err_hit  = 1'b0;
    exp_n    = exp_order;
    drop_exp = exp_order;
    for (int j = 0; j < NRET; j++) push_data[j] = '0;
    for (int i = 0; i < NRET; i++)
      if (verif_commit_valid[i]) begin
        n_valid  = n_valid + 1;
        drop_exp = lane_rec[i].order + ORDER_W'(1);
        if (!halt_hit) begin
          for (int j = 0; j < NRET; j++) if (j == n_push) push_data[j] = lane_rec[i];
          if ((seen || n_push != 0) && lane_rec[i].order != exp_n) err_hit = 1'b1;
          exp_n    = lane_rec[i].order + ORDER_W'(1);
          n_push   = n_push + 1;
          halt_hit = lane_rec[i].halt;
        end
      end
    free   = DEPTH - int'(count) + int'(pop);
    accept = (state == RUN) && (n_valid != 0) && (free >= n_valid);
    drop   = (state == RUN) && (n_valid != 0) && (free < n_valid);
  end
  always_comb
    state_n = (state == RUN && accept && halt_hit) ? DRAIN :
              (state == DRAIN && count == '0)      ? DONE  : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= RUN;
      exp_order <= '0;
      seen      <= 1'b0;
      order_err <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        exp_order <= exp_n;
        seen      <= 1'b1;
        if (err_hit) order_err <= 1'b1;
      end else if (drop) begin
        exp_order <= drop_exp;
        overflow  <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  trace_fifo #(.DEPTH(DEPTH), .ENQ_W(NRET)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_n   (NW'(accept ? n_push : 0)),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );
  assign halt_done    = (state == DONE);
  assign out_prevPc   = XLEN'(head.prevPc);
  assign out_currPc   = XLEN'(head.currPc);
  assign out_order    = head.order;
  assign out_insn     = head.insn;
  assign out_flags    = {head.halt, head.isStore, head.mem_valid, head.gprWr, head.fused};
  assign out_dest_idx = head.dest_idx;
  assign out_mem_addr = XLEN'(head.mem_addr);
endmodule

// File: tb/tb_commit_trace_serializer.sv
// tb_commit_trace_serializer: random and directed retire bundles checked against a queue model
module tb_commit_trace_serializer;
  localparam int NRET = 2, XLEN = 64, DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic [NRET-1:0] c_valid, c_fused, c_halt, d_gpr, m_valid, m_store;
  logic [NRET*XLEN-1:0] c_prev, c_curr, m_addr;
  logic [NRET*10-1:0] c_order;
  logic [NRET*32-1:0] c_insn;
  logic [NRET*8-1:0] d_idx;
  logic out_valid, out_ready, overflow, order_err, halt_done;
  logic [XLEN-1:0] out_prevPc, out_currPc, out_mem_addr;
  logic [9:0] out_order;
  logic [31:0] out_insn;
  logic [4:0] out_flags;
  logic [7:0] out_dest_idx;
  logic [15:0] drop_cnt;
  typedef struct {
    logic [63:0] prev, curr, addr;
    logic [9:0]  ord;
    logic [31:0] insn;
    logic [7:0]  dest;
    logic [4:0]  flags;
  } rec_t;
  rec_t q[$];
  int checks = 0, errors = 0, mstate = 0;
  logic [9:0] mexp, nxt;
  logic mseen, moerr, movf;
  logic [15:0] mdcnt;
  always #5 clk = ~clk;
  commit_trace_serializer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .verif_commit_valid(c_valid), .verif_commit_prevPc(c_prev), .verif_commit_currPc(c_curr),
    .verif_commit_order(c_order), .verif_commit_insn(c_insn), .verif_commit_fused(c_fused),
    .verif_sim_halt(c_halt), .verif_dest_gprWr(d_gpr), .verif_dest_idx(d_idx),
    .verif_mem_valid(m_valid), .verif_mem_isStore(m_store), .verif_mem_addr(m_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_prevPc(out_prevPc), .out_currPc(out_currPc),
    .out_order(out_order), .out_insn(out_insn), .out_flags(out_flags), .out_dest_idx(out_dest_idx),
    .out_mem_addr(out_mem_addr), .overflow(overflow), .drop_cnt(drop_cnt), .order_err(order_err),
    .halt_done(halt_done)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mstate = 0; mexp = '0; mseen = 1'b0; moerr = 1'b0; movf = 1'b0; mdcnt = '0;
  endtask
  task automatic compare();
    logic mv;
    mv = q.size() > 0 && mstate != 2;
    check("out_valid", 64'(out_valid), 64'(mv));
    if (mv) begin
      check("prevPc", out_prevPc, q[0].prev);
      check("currPc", out_currPc, q[0].curr);
      check("mem_addr", out_mem_addr, q[0].addr);
      check("order", 64'(out_order), 64'(q[0].ord));
      check("insn", 64'(out_insn), 64'(q[0].insn));
      check("dest_idx", 64'(out_dest_idx), 64'(q[0].dest));
      check("flags", 64'(out_flags), 64'(q[0].flags));
    end
    check("overflow", 64'(overflow), 64'(movf));
    check("drop_cnt", 64'(drop_cnt), 64'(mdcnt));
    check("order_err", 64'(order_err), 64'(moerr));
    check("halt_done", 64'(halt_done), 64'(mstate == 2));
  endtask
  // One clock: compare outputs, drive a bundle, then advance the model by that cycle
  task automatic cyc(input logic [1:0] v, input logic [1:0] h, input logic [9:0] o0,
                     input logic [9:0] o1, input logic rdy);
    rec_t r[2];
    int n, nstate;
    bit pop;
    @(negedge clk);
    compare();
    for (int i = 0; i < 2; i++) begin
      r[i].prev  = {$urandom, $urandom};
      r[i].curr  = {$urandom, $urandom};
      r[i].addr  = {$urandom, $urandom};
      r[i].ord   = i ? o1 : o0;
      r[i].insn  = $urandom;
      r[i].dest  = 8'($urandom);
      r[i].flags = {h[i], 4'($urandom)};
      c_prev[i*64 +: 64] = r[i].prev;
      c_curr[i*64 +: 64] = r[i].curr;
      m_addr[i*64 +: 64] = r[i].addr;
      c_order[i*10 +: 10] = r[i].ord;
      c_insn[i*32 +: 32] = r[i].insn;
      d_idx[i*8 +: 8] = r[i].dest;
      c_fused[i] = r[i].flags[0];
      d_gpr[i]   = r[i].flags[1];
      m_valid[i] = r[i].flags[2];
      m_store[i] = r[i].flags[3];
      c_halt[i]  = h[i];
    end
    c_valid = v;
    out_ready = rdy;
    pop = q.size() > 0 && mstate != 2 && rdy;
    nstate = mstate;
    n = $countones(v);
    if (mstate == 0 && n > 0) begin
      if (DEPTH - q.size() + int'(pop) >= n) begin
        for (int i = 0; i < 2; i++)
          if (v[i]) begin
            if (mseen && r[i].ord != mexp) moerr = 1'b1;
            mexp = r[i].ord + 10'd1;
            mseen = 1'b1;
            q.push_back(r[i]);
            if (h[i]) begin
              nstate = 1;
              break;
            end
          end
      end else begin
        movf = 1'b1;
        if (mdcnt != 16'hFFFF) mdcnt++;
        mexp = (v[1] ? o1 : o0) + 10'd1;
      end
    end else if (mstate == 1 && q.size() == 0) nstate = 2;
    if (pop) void'(q.pop_front());
    mstate = nstate;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_overflow", 64'(overflow), 64'd0);
    check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("arst_order_err", 64'(order_err), 64'd0);
    check("arst_prevPc", out_prevPc, 64'd0);
    model_reset();
    c_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    logic [1:0] v;
    logic [9:0] o0, o1;
    {c_valid, c_fused, c_halt, d_gpr, m_valid, m_store} = '0;
    {c_prev, c_curr, m_addr, c_order, c_insn, d_idx} = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_prevPc", out_prevPc, 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 7; i++) cyc(2'b01, 2'b00, 10'(i), 10'd0, 1'b1);
    cyc(2'b11, 2'b00, 10'd7, 10'd8, 1'b1);
    cyc(2'b10, 2'b00, 10'd0, 10'd9, 1'b1);
    repeat (3) cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    check("seq_order_err", 64'(order_err), 64'd0);
    for (int i = 0; i < 5; i++) cyc(2'b11, 2'b00, 10'(10 + 2*i), 10'(11 + 2*i), 1'b0);
    cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b0);
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_drop_cnt", 64'(drop_cnt), 64'd1);
    check("bp_order", 64'(out_order), 64'd10);
    repeat (4) cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    do_reset();
    cyc(2'b01, 2'b00, 10'd1022, 10'd0, 1'b1);
    cyc(2'b01, 2'b00, 10'd1023, 10'd0, 1'b1);
    cyc(2'b01, 2'b00, 10'd0, 10'd0, 1'b1);
    cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    check("wrap_order_err", 64'(order_err), 64'd0);
    cyc(2'b01, 2'b00, 10'd5, 10'd0, 1'b1);
    repeat (2) cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    check("jump_order_err", 64'(order_err), 64'd1);
    do_reset();
    nxt = '0;
    repeat (400) begin
      v = 2'($urandom);
      if ($urandom_range(15) == 0) nxt = 10'($urandom);
      o0 = nxt;
      if (v[0]) nxt = nxt + 10'd1;
      o1 = nxt;
      if (v[1]) nxt = nxt + 10'd1;
      cyc(v, 2'b00, o0, o1, $urandom_range(3) != 0);
    end
    repeat (12) cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b00, nxt, 10'd0, 1'b0);
      nxt = nxt + 10'd1;
    end
    cyc(2'b11, 2'b01, nxt, nxt + 10'd1, 1'b0);
    repeat (6) cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    check("halt_done", 64'(halt_done), 64'd1);
    repeat (5) cyc(2'b11, 2'b00, 10'd100, 10'd101, 1'b1);
    cyc(2'b00, 2'b00, 10'd0, 10'd0, 1'b1);
    check("done_valid", 64'(out_valid), 64'd0);
    check("done_held", 64'(halt_done), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
